hwpe_ctrl_cfg_arbiter: RTL and testbench

Round-robin arbiter that shares the single HWPE peripheral configuration port among N_PORTS requesting cores. It adds an acquire lock: a port whose acquire read succeeds keeps exclusive access until it triggers the job, issues a soft clear, or times out. This lets multi-core offload sequences (acquire, program, trigger) run without interleaving. It sits between the cluster peripheral interconnect and the HWPE control slave.

---
 rtl/hwpe_ctrl_cfg_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_hwpe_ctrl_cfg_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_cfg_arbiter.sv
// Round-robin arbiter sharing one HWPE config port among N_PORTS cores, with an acquire lock.
// Latency: request and response paths are combinational (zero added cycles); state/lock flags registered.
// Backpressure: losers and non-owners see gnt_o=0 and hold; nothing is forwarded while an acquire is in flight.
module hwpe_ctrl_cfg_arbiter #(
    parameter int unsigned N_PORTS      = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      clear_i,
    input  logic [N_PORTS-1:0]                        req_i,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]        add_i,
    input  logic [N_PORTS-1:0]                        wen_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]      be_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]        data_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]          id_i,
    output logic [N_PORTS-1:0]                        gnt_o,
    output logic [DATA_WIDTH-1:0]                     r_data_o,
    output logic [N_PORTS-1:0]                        r_valid_o,
    output logic [ID_WIDTH-1:0]                       r_id_o,
    output logic                                      req_o,
    output logic [ADDR_WIDTH-1:0]                     add_o,
    output logic                                      wen_o,
    output logic [DATA_WIDTH/8-1:0]                   be_o,
    output logic [DATA_WIDTH-1:0]                     data_o,
    output logic [ID_WIDTH-1:0]                       id_o,
    input  logic                                      gnt_i,
    input  logic [DATA_WIDTH-1:0]                     r_data_i,
    input  logic                                      r_valid_i,
    input  logic [ID_WIDTH-1:0]                       r_id_i,
    output logic                                      locked_o,
    output logic [$clog2(N_PORTS)-1:0]                owner_o,
    output logic                                      timeout_o
);

    localparam int unsigned PW = $clog2(N_PORTS);
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQ_WAIT = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   acq_port_q, acq_port_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   resp_port_q, resp_port_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            locked_q, locked_d;
    logic            timeout_q, timeout_d;

    logic [PW-1:0]   cand;
    logic [PW-1:0]   win_port;
    logic            win_vld;
    logic [PW-1:0]   sel_port;
    logic            fwd_vld;
    logic            hs;
    logic [7:0]      sel_idx;
    logic            sel_acq;
    logic            sel_trig;
    logic            sel_sclr;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (p == LAST_PORT) ? '0 : p + PW'(1);
    endfunction

    // Descending scan so the smallest offset from rr_ptr_q is the last (winning) assignment.
    always_comb begin
        win_vld  = 1'b0;
        win_port = '0;
        cand     = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_ptr_q) + k) % N_PORTS);
            if (req_i[cand]) begin
                win_vld  = 1'b1;
                win_port = cand;
            end
        end
    end

    always_comb begin
        sel_port = '0;
        fwd_vld  = 1'b0;
        case (state_q)
            IDLE: begin
                sel_port = win_port;
                fwd_vld  = win_vld;
            end
            LOCKED: begin
                sel_port = owner_q;
                fwd_vld  = req_i[owner_q];
            end
            default: begin
                sel_port = '0;
                fwd_vld  = 1'b0;
            end
        endcase
        // Nothing is handed to the slave in a clear cycle, so no response can lose its routing.
        if (clear_i) begin
            fwd_vld = 1'b0;
        end
    end

    assign hs       = fwd_vld & gnt_i;
    assign sel_idx  = add_i[sel_port][9:2];
    assign sel_acq  =  wen_i[sel_port] && (sel_idx == 8'd1);
    assign sel_trig = !wen_i[sel_port] && (sel_idx == 8'd0);
    assign sel_sclr = !wen_i[sel_port] && (sel_idx == 8'd5);

    assign req_o  = fwd_vld;
    assign add_o  = add_i[sel_port];
    assign wen_o  = wen_i[sel_port];
    assign be_o   = be_i[sel_port];
    assign data_o = data_i[sel_port];
    assign id_o   = id_i[sel_port];

    always_comb begin
        gnt_o = '0;
        if (fwd_vld) begin
            gnt_o[sel_port] = gnt_i;
        end
    end

    always_comb begin
        r_valid_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            r_valid_o[k] = r_valid_i && (resp_port_q == PW'(k));
        end
    end

    assign r_data_o  = r_data_i;
    assign r_id_o    = r_id_i;
    assign locked_o  = locked_q;
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        acq_port_d  = acq_port_q;
        owner_d     = owner_q;
        resp_port_d = resp_port_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;

        if (hs) begin
            resp_port_d = sel_port;
        end

        case (state_q)
            IDLE: begin
                if (hs) begin
                    rr_ptr_d = next_port(sel_port);
                    if (sel_acq) begin
                        state_d    = ACQ_WAIT;
                        acq_port_d = sel_port;
                    end
                end
            end
            ACQ_WAIT: begin
                if (r_valid_i) begin
                    if (!r_data_i[DATA_WIDTH-1]) begin
                        state_d = LOCKED;
                        owner_d = acq_port_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (hs) begin
                    cnt_d = '0;
                    if (sel_trig || sel_sclr) begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // A pending owner request at expiry keeps the lock and restarts the count.
                    cnt_d = '0;
                    if (!req_i[owner_q]) begin
                        state_d   = IDLE;
                        owner_d   = '0;
                        timeout_d = 1'b1;
                        rr_ptr_d  = next_port(owner_q);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase

        if (clear_i) begin
            state_d     = IDLE;
            rr_ptr_d    = '0;
            acq_port_d  = '0;
            owner_d     = '0;
            resp_port_d = '0;
            cnt_d       = '0;
            timeout_d   = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            acq_port_q  <= '0;
            owner_q     <= '0;
            resp_port_q <= '0;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            acq_port_q  <= acq_port_d;
            owner_q     <= owner_d;
            resp_port_q <= resp_port_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == ACQ_WAIT) |-> !req_o);

endmodule

// File: tb/tb_hwpe_ctrl_cfg_arbiter.sv
// Bench for hwpe_ctrl_cfg_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the arbitration/lock rules.
module tb_hwpe_ctrl_cfg_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int LT = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       clear_i = 1'b0;
    logic [N-1:0]               req_i = '0;
    logic [N-1:0][AW-1:0]       add_i = '0;
    logic [N-1:0]               wen_i = '0;
    logic [N-1:0][DW/8-1:0]     be_i = '0;
    logic [N-1:0][DW-1:0]       data_i = '0;
    logic [N-1:0][IW-1:0]       id_i = '0;
    logic [N-1:0]               gnt_o;
    logic [DW-1:0]              r_data_o;
    logic [N-1:0]               r_valid_o;
    logic [IW-1:0]              r_id_o;
    logic                       req_o;
    logic [AW-1:0]              add_o;
    logic                       wen_o;
    logic [DW/8-1:0]            be_o;
    logic [DW-1:0]              data_o;
    logic [IW-1:0]              id_o;
    logic                       gnt_i = 1'b1;
    logic [DW-1:0]              r_data_i = '0;
    logic                       r_valid_i = 1'b0;
    logic [IW-1:0]              r_id_i = '0;
    logic                       locked_o;
    logic [1:0]                 owner_o;
    logic                       timeout_o;

    hwpe_ctrl_cfg_arbiter #(
        .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
        .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i),
        .gnt_o(gnt_o), .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_id_o(r_id_o),
        .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .be_o(be_o), .data_o(data_o), .id_o(id_o),
        .gnt_i(gnt_i), .r_data_i(r_data_i), .r_valid_i(r_valid_i), .r_id_i(r_id_i),
        .locked_o(locked_o), .owner_o(owner_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle, 1=waiting for acquire response, 2=locked.
    int m_mode = 0, m_rr = 0, m_owner = 0, m_acq = 0, m_resp = 0, m_cnt = 0, m_tp = 0;
    int n_mode = 0, n_rr = 0, n_owner = 0, n_acq = 0, n_resp = 0, n_cnt = 0, n_tp = 0;

    initial begin
        forever begin
            int fwd, ereq, widx, hs;
            logic [N-1:0] egnt, ervld;
            @(negedge clk);
            if (!rst_n) begin
                n_mode = 0; n_rr = 0; n_owner = 0; n_acq = 0; n_resp = 0; n_cnt = 0; n_tp = 0;
                chk("rst_locked", locked_o, 0);
                chk("rst_owner", owner_o, 0);
                chk("rst_timeout", timeout_o, 0);
            end else begin
                fwd = 0; ereq = 0;
                if (m_mode == 0) begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (req_i[(m_rr + k) % N]) begin fwd = (m_rr + k) % N; ereq = 1; end
                    end
                end else if (m_mode == 2) begin
                    fwd = m_owner; ereq = int'(req_i[m_owner]);
                end
                if (clear_i) ereq = 0;
                egnt = '0;
                if (ereq != 0) egnt[fwd] = gnt_i;
                ervld = r_valid_i ? (N'(1) << m_resp) : '0;
                chk("gnt_o", gnt_o, egnt);
                chk("req_o", req_o, ereq);
                chk("r_valid_o", r_valid_o, ervld);
                chk("r_data_o", r_data_o, r_data_i);
                chk("r_id_o", r_id_o, r_id_i);
                chk("locked_o", locked_o, m_mode == 2);
                chk("owner_o", owner_o, (m_mode == 2) ? m_owner : 0);
                chk("timeout_o", timeout_o, m_tp);
                if (ereq != 0) begin
                    chk("add_o", add_o, add_i[fwd]);
                    chk("wen_o", wen_o, wen_i[fwd]);
                    chk("be_o", be_o, be_i[fwd]);
                    chk("data_o", data_o, data_i[fwd]);
                    chk("id_o", id_o, id_i[fwd]);
                end
                widx = int'(add_i[fwd][9:2]);
                hs = ereq & int'(gnt_i);
                n_mode = m_mode; n_rr = m_rr; n_owner = m_owner; n_acq = m_acq;
                n_resp = m_resp; n_cnt = m_cnt; n_tp = 0;
                if (clear_i) begin
                    n_mode = 0; n_rr = 0; n_owner = 0; n_acq = 0; n_resp = 0; n_cnt = 0;
                end else begin
                    if (hs != 0) n_resp = fwd;
                    if (m_mode == 0) begin
                        if (hs != 0) begin
                            n_rr = (fwd + 1) % N;
                            if (wen_i[fwd] && widx == 1) begin n_mode = 1; n_acq = fwd; end
                        end
                    end else if (m_mode == 1) begin
                        if (r_valid_i) begin
                            if (!r_data_i[DW-1]) begin n_mode = 2; n_owner = m_acq; n_cnt = 0; end
                            else n_mode = 0;
                        end
                    end else begin
                        if (hs != 0) begin
                            n_cnt = 0;
                            if (!wen_i[fwd] && (widx == 0 || widx == 5)) n_mode = 0;
                        end else if (m_cnt == LT - 1) begin
                            n_cnt = 0;
                            if (!req_i[m_owner]) begin n_mode = 0; n_tp = 1; n_rr = (m_owner + 1) % N; end
                        end else begin
                            n_cnt = m_cnt + 1;
                        end
                    end
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                m_mode = 0; m_rr = 0; m_owner = 0; m_acq = 0; m_resp = 0; m_cnt = 0; m_tp = 0;
            end else begin
                m_mode = n_mode; m_rr = n_rr; m_owner = n_owner; m_acq = n_acq;
                m_resp = n_resp; m_cnt = n_cnt; m_tp = n_tp;
            end
        end
    end

    logic [DW-1:0] resp_data = 32'h1234_5678;

    // Slave behaviour: r_valid exactly one cycle after each handshake.
    task automatic advance();
        logic hs;
        logic [IW-1:0] hid;
        hs  = rst_n && req_o && gnt_i;
        hid = id_o;
        @(posedge clk);
        #1;
        r_valid_i = hs && rst_n;
        r_id_i    = hs ? hid : '0;
        r_data_i  = resp_data;
    endtask

    task automatic set_port(input int p, input logic rq, input logic wn, input logic [7:0] idx);
        req_i[p]  = rq;
        wen_i[p]  = wn;
        add_i[p]  = {22'h0, idx, 2'b00};
        be_i[p]   = 4'hF;
        data_i[p] = 32'hD000_0000 + p;
        id_i[p]   = 16'h0100 + 16'(p);
    endtask

    task automatic new_trans(input int p);
        logic [31:0] r;
        logic [7:0]  wi;
        int pick;
        r = $urandom;
        pick = $urandom_range(0, 5);
        case (pick)
            0:       wi = 8'd0;
            1, 2:    wi = 8'd1;
            3:       wi = 8'd5;
            default: wi = 8'(3 + pick);
        endcase
        req_i[p]  = 1'b1;
        wen_i[p]  = 1'($urandom_range(0, 1));
        add_i[p]  = {r[31:10], wi, r[1:0]};
        be_i[p]   = 4'($urandom);
        data_i[p] = $urandom;
        id_i[p]   = 16'($urandom);
    endtask

    initial begin
        logic [N-1:0] gseen;
        int quiet [N];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Alternating round robin between ports 0 and 2.
        set_port(0, 1, 1, 8'd3);
        set_port(2, 1, 1, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt", gnt_o, (i % 2) ? 4'b0100 : 4'b0001);
            if (i > 0) begin
                chk("rr_rvalid", r_valid_o, (i % 2) ? 4'b0001 : 4'b0100);
                chk("rr_rid", r_id_o, (i % 2) ? 16'h0100 : 16'h0102);
            end
            advance();
        end
        req_i = '0;
        @(negedge clk);
        chk("rr_rvalid_last", r_valid_o, 4'b0100);
        advance();

        // Port 1 acquires, port 3 stalls until the trigger.
        set_port(1, 1, 1, 8'd1);
        resp_data = 32'h0;
        @(negedge clk); chk("acq_gnt", gnt_o, 4'b0010); advance();
        resp_data = 32'h1234_5678;
        req_i[1] = 1'b0; set_port(3, 1, 0, 8'd3);
        @(negedge clk);
        chk("acqw_gnt", gnt_o, 0); chk("acqw_req", req_o, 0);
        chk("acqw_rvalid", r_valid_o, 4'b0010); chk("acqw_locked", locked_o, 0);
        advance();
        @(negedge clk);
        chk("lock_locked", locked_o, 1); chk("lock_owner", owner_o, 1); chk("lock_gnt", gnt_o, 0);
        advance();
        set_port(1, 1, 0, 8'd3);
        @(negedge clk); chk("own_prog_gnt", gnt_o, 4'b0010); advance();
        set_port(1, 1, 0, 8'd0);
        @(negedge clk); chk("own_trig_gnt", gnt_o, 4'b0010); advance();
        req_i[1] = 1'b0;
        @(negedge clk); chk("unlock_locked", locked_o, 0); chk("unlock_gnt3", gnt_o, 4'b1000); advance();
        req_i = '0;

        // Failed acquire from port 2.
        set_port(2, 1, 1, 8'd1);
        resp_data = 32'hFFFF_FFFF;
        @(negedge clk); chk("facq_gnt", gnt_o, 4'b0100); advance();
        resp_data = 32'h1234_5678;
        req_i[2] = 1'b0; set_port(0, 1, 1, 8'd3);
        @(negedge clk); chk("facq_wait_gnt", gnt_o, 0); advance();
        @(negedge clk); chk("facq_locked", locked_o, 0); chk("facq_gnt0", gnt_o, 4'b0001); advance();
        req_i = '0;

        // Port 0 locks then goes silent: forced release.
        set_port(0, 1, 1, 8'd1);
        resp_data = 32'h0;
        @(negedge clk); chk("to_acq_gnt", gnt_o, 4'b0001); advance();
        resp_data = 32'h1234_5678;
        req_i[0] = 1'b0;
        @(negedge clk); advance();
        set_port(0, 1, 0, 8'd3);
        @(negedge clk); chk("to_own_gnt", gnt_o, 4'b0001); chk("to_locked", locked_o, 1); advance();
        req_i[0] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("to_wait_pulse", timeout_o, 0);
            chk("to_wait_locked", locked_o, 1);
            advance();
        end
        @(negedge clk); chk("to_pulse", timeout_o, 1); chk("to_released", locked_o, 0); advance();
        set_port(0, 1, 1, 8'd3); set_port(1, 1, 1, 8'd3);
        @(negedge clk); chk("to_pulse_end", timeout_o, 0); chk("to_rr_ptr1", gnt_o, 4'b0010); advance();
        req_i = '0;

        // Clear while port 3 holds the lock.
        set_port(3, 1, 1, 8'd1);
        resp_data = 32'h0;
        @(negedge clk); chk("clr_acq_gnt", gnt_o, 4'b1000); advance();
        resp_data = 32'h1234_5678;
        req_i[3] = 1'b0;
        @(negedge clk); advance();
        set_port(3, 1, 0, 8'd3); set_port(1, 1, 1, 8'd3);
        clear_i = 1'b1;
        @(negedge clk); chk("clr_owner3", owner_o, 3); chk("clr_cycle_gnt", gnt_o, 0); advance();
        clear_i = 1'b0;
        @(negedge clk);
        chk("clr_locked", locked_o, 0); chk("clr_owner", owner_o, 0); chk("clr_rr_gnt", gnt_o, 4'b0010);
        advance();
        req_i = '0;

        // Asynchronous reset in the middle of a locked owner transaction.
        set_port(0, 1, 1, 8'd1);
        resp_data = 32'h0;
        @(negedge clk); chk("ar_acq_gnt", gnt_o, 4'b0001); advance();
        resp_data = 32'h1234_5678;
        req_i[0] = 1'b0;
        @(negedge clk); advance();
        set_port(0, 1, 0, 8'd3);
        @(negedge clk); chk("ar_own_gnt", gnt_o, 4'b0001); chk("ar_locked_pre", locked_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_locked", locked_o, 0); chk("ar_owner", owner_o, 0); chk("ar_timeout", timeout_o, 0);
        req_i = '0; r_valid_i = 1'b0; r_id_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("ar_no_rvalid", r_valid_o, 0); chk("ar_no_req", req_o, 0); chk("ar_no_gnt", gnt_o, 0);
            advance();
        end

        // Random traffic against the model.
        for (int p = 0; p < N; p++) quiet[p] = 0;
        for (int c = 0; c < 3000; c++) begin
            clear_i   = ($urandom_range(0, 63) == 0);
            gnt_i     = ($urandom_range(0, 3) != 0);
            resp_data = $urandom;
            for (int p = 0; p < N; p++) begin
                if (!req_i[p]) begin
                    if (quiet[p] > 0) quiet[p]--;
                    else if ($urandom_range(0, 1) == 1) new_trans(p);
                end
            end
            @(negedge clk);
            gseen = gnt_o;
            advance();
            for (int p = 0; p < N; p++) begin
                if (gseen[p]) begin
                    req_i[p] = 1'b0;
                    if ($urandom_range(0, 5) == 0) quiet[p] = $urandom_range(4, 14);
                end
            end
        end
        clear_i = 1'b0;
        req_i = '0;
        gnt_i = 1'b1;
        repeat (LT + 4) begin
            @(negedge clk);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
